// File: rtl/tape_pkg.sv
// tape_pkg: shared state encoding, bank defaults and FIFO entry layout for the tape loader.
package tape_pkg;
    typedef enum logic [2:0] {IDLE, BANK_SET, LOAD, DRAIN, BANK_RESTORE, DONE} tape_state_t;
    localparam logic [7:0]  BANK_LOAD_DEF = 8'h00;
    localparam logic [7:0]  BANK_RUN_DEF  = 8'h20;
    localparam logic [15:0] BANK_ADDR_DEF = 16'hFFFF;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } tape_entry_t;
endpackage

// File: rtl/tape_byte_fifo.sv
// tape_byte_fifo: first-word-fall-through FIFO of address/data entries; push on full is accepted only alongside a pop.
module tape_byte_fifo
    import tape_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  tape_entry_t i_din,
    output tape_entry_t o_dout,
    output logic        o_full,
    output logic        o_empty
);
    localparam int AW = $clog2(DEPTH);
    tape_entry_t r_mem [DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        w_wr, w_rd;
    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/tape_load_sequencer.sv
// tape_load_sequencer: holds the CPU, banks RAM in for the load, writes parsed tape bytes
// in idle bus cycles through a small FIFO, then restores the run bank and pulses done.
module tape_load_sequencer
    import tape_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  BANK_LOAD  = BANK_LOAD_DEF,
    parameter logic [7:0]  BANK_RUN   = BANK_RUN_DEF,
    parameter logic [15:0] BANK_ADDR  = BANK_ADDR_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ioctl_download,
    input  logic        i_tape_wr,
    input  logic [15:0] i_tape_addr,
    input  logic [7:0]  i_tape_dout,
    input  logic        i_cpu_mem_busy,
    output logic        o_ram_we,
    output logic [15:0] o_ram_addr,
    output logic [7:0]  o_ram_din,
    output logic        o_bank_we,
    output logic [7:0]  o_bank_dout,
    output logic        o_cpu_wait,
    output logic        o_load_done,
    output logic        o_overflow,
    output logic [15:0] o_byte_count
);
    tape_state_t r_state;
    logic        r_dl_prev, r_last_valid, r_ram_we, r_bank_we, r_cpu_wait, r_load_done, r_overflow;
    logic [15:0] r_last_addr, r_ram_addr, r_byte_count;
    logic [7:0]  r_ram_din, r_bank_dout;
    logic        w_push, w_pop, w_full, w_empty;
    tape_entry_t w_head;
    assign w_push = (r_state == LOAD) && i_tape_wr && (!r_last_valid || i_tape_addr != r_last_addr);
    assign w_pop  = (r_state == LOAD || r_state == DRAIN) && !w_empty && !i_cpu_mem_busy;
    tape_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_din    ({i_tape_addr, i_tape_dout}),
        .o_dout   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_dl_prev    <= 1'b0;
            r_last_valid <= 1'b0;
            r_last_addr  <= '0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_bank_we    <= 1'b0;
            r_bank_dout  <= '0;
            r_cpu_wait   <= 1'b0;
            r_load_done  <= 1'b0;
            r_overflow   <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_dl_prev   <= i_ioctl_download;
            r_ram_we    <= 1'b0;
            r_bank_we   <= 1'b0;
            r_load_done <= 1'b0;
            if (w_pop) begin
                r_ram_we     <= 1'b1;
                r_ram_addr   <= w_head.addr;
                r_ram_din    <= w_head.data;
                r_byte_count <= r_byte_count + 16'd1;
            end
            if (w_push) begin
                r_last_addr  <= i_tape_addr;
                r_last_valid <= 1'b1;
                if (w_full && !w_pop) r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: if (i_ioctl_download && !r_dl_prev) begin
                    r_state      <= BANK_SET;
                    r_cpu_wait   <= 1'b1;
                    r_overflow   <= 1'b0;
                    r_byte_count <= '0;
                    r_last_valid <= 1'b0;
                end
                BANK_SET: if (!i_cpu_mem_busy) begin
                    r_bank_we   <= 1'b1;
                    r_bank_dout <= BANK_LOAD;
                    r_ram_addr  <= BANK_ADDR;
                    r_state     <= LOAD;
                end
                // Level test also catches a download that ended before LOAD was reached.
                LOAD: if (!i_ioctl_download) r_state <= DRAIN;
                DRAIN: if (w_empty && !r_ram_we) r_state <= BANK_RESTORE;
                BANK_RESTORE: if (!i_cpu_mem_busy) begin
                    r_bank_we   <= 1'b1;
                    r_bank_dout <= BANK_RUN;
                    r_state     <= DONE;
                end
                DONE: begin
                    r_load_done <= 1'b1;
                    r_cpu_wait  <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_ram_we     = r_ram_we;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_din    = r_ram_din;
    assign o_bank_we    = r_bank_we;
    assign o_bank_dout  = r_bank_dout;
    assign o_cpu_wait   = r_cpu_wait;
    assign o_load_done  = r_load_done;
    assign o_overflow   = r_overflow;
    assign o_byte_count = r_byte_count;
endmodule

// File: tb/tb_tape_load_sequencer.sv
// tb_tape_load_sequencer: scenario tasks with a scoreboard of expected RAM and bank writes.
module tb_tape_load_sequencer;
    logic        clk = 1'b0, reset_n = 1'b0, dl = 1'b0, twr = 1'b0, busy = 1'b0;
    logic [15:0] taddr = '0;
    logic [7:0]  tdout = '0;
    logic        ram_we, bank_we, cpu_wait, load_done, overflow;
    logic [15:0] ram_addr, byte_count;
    logic [7:0]  ram_din, bank_dout;
    int          errors = 0, checks = 0, n_wr = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  bank_q[$];
    logic [23:0] m_exp;
    logic [7:0]  m_bank;

    tape_load_sequencer dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_ioctl_download(dl), .i_tape_wr(twr),
        .i_tape_addr(taddr), .i_tape_dout(tdout), .i_cpu_mem_busy(busy),
        .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_din(ram_din),
        .o_bank_we(bank_we), .o_bank_dout(bank_dout), .o_cpu_wait(cpu_wait),
        .o_load_done(load_done), .o_overflow(overflow), .o_byte_count(byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we) begin
            n_wr++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ram_write: unexpected write got addr=%h data=%h, required none", ram_addr, ram_din);
            end else begin
                m_exp = exp_q.pop_front();
                if ({ram_addr, ram_din} !== m_exp) begin
                    errors++;
                    $display("FAIL ram_write: got %h_%h required %h_%h", ram_addr, ram_din, m_exp[23:8], m_exp[7:0]);
                end
            end
        end
        if (bank_we) begin
            checks++;
            if (ram_we) begin
                errors++;
                $display("FAIL strobe_excl: ram_we=%b with bank_we=1, required ram_we=0", ram_we);
            end
            if (bank_q.size() == 0) begin
                errors++;
                $display("FAIL bank_write: unexpected bank_we got %h, required none", bank_dout);
            end else begin
                m_bank = bank_q.pop_front();
                if (bank_dout !== m_bank) begin
                    errors++;
                    $display("FAIL bank_write: got %h required %h", bank_dout, m_bank);
                end
            end
        end
    end

    task automatic start_load();
        bit ok;
        ok = 0;
        dl = 1'b1;
        bank_q.push_back(8'h00);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bank_we) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL start_load: bank_we got 0 within 20 cycles, required 1");
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] d, input bit cap);
        twr = 1'b1;
        taddr = a;
        tdout = d;
        if (cap) exp_q.push_back({a, d});
        @(negedge clk);
        twr = 1'b0;
    endtask

    task automatic end_load();
        dl = 1'b0;
        bank_q.push_back(8'h20);
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (load_done) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done: load_done got 0 within 100 cycles, required 1", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ram_we, bank_we, cpu_wait, load_done, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000", {ram_we, bank_we, cpu_wait, load_done, overflow});
        end
        checks++;
        if ({ram_addr, ram_din, bank_dout, byte_count} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {ram_addr, ram_din, bank_dout, byte_count});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int w0;
        w0 = n_wr;
        start_load();
        checks++;
        if (cpu_wait !== 1'b1) begin
            errors++;
            $display("FAIL basic_wait: cpu_wait got %b required 1", cpu_wait);
        end
        send(16'h694D, 8'hA1, 1);
        send(16'h694E, 8'hB2, 1);
        send(16'h694F, 8'hC3, 1);
        end_load();
        wait_done("basic");
        checks++;
        if (cpu_wait !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait_end: cpu_wait got %b required 0", cpu_wait);
        end
        checks++;
        if (n_wr - w0 !== 3 || byte_count !== 16'd3) begin
            errors++;
            $display("FAIL basic_count: writes=%0d byte_count=%0d required 3/3", n_wr - w0, byte_count);
        end
        checks++;
        if (exp_q.size() != 0 || bank_q.size() != 0) begin
            errors++;
            $display("FAIL basic_pending: ram=%0d bank=%0d outstanding required 0/0", exp_q.size(), bank_q.size());
        end
    endtask

    task automatic test_held_wr();
        int w0;
        w0 = n_wr;
        start_load();
        twr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            taddr = (i < 3) ? 16'h1000 : 16'h1001;
            tdout = (i < 3) ? 8'h5A : 8'h6B;
            if (i == 0 || i == 3) exp_q.push_back({taddr, tdout});
            @(negedge clk);
        end
        twr = 1'b0;
        end_load();
        wait_done("held");
        checks++;
        if (n_wr - w0 !== 2 || byte_count !== 16'd2) begin
            errors++;
            $display("FAIL held_count: writes=%0d byte_count=%0d required 2/2", n_wr - w0, byte_count);
        end
    endtask

    task automatic test_overflow();
        int w0;
        w0 = n_wr;
        start_load();
        busy = 1'b1;
        for (int i = 0; i < 6; i++) send(16'h2000 + 16'(i), 8'h30 + 8'(i), i < 4);
        checks++;
        if (overflow !== 1'b1 || n_wr - w0 !== 0) begin
            errors++;
            $display("FAIL ovf_flag: overflow=%b writes=%0d required 1/0", overflow, n_wr - w0);
        end
        busy = 1'b0;
        end_load();
        wait_done("ovf");
        checks++;
        if (n_wr - w0 !== 4 || byte_count !== 16'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_count: writes=%0d byte_count=%0d overflow=%b required 4/4/1", n_wr - w0, byte_count, overflow);
        end
    endtask

    task automatic test_full_pushpop();
        int w0;
        w0 = n_wr;
        start_load();
        busy = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h3000 + 16'(i), 8'h40 + 8'(i), 1);
        busy = 1'b0;
        send(16'h3004, 8'h44, 1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop: overflow got %b required 0", overflow);
        end
        end_load();
        wait_done("full");
        checks++;
        if (n_wr - w0 !== 5 || byte_count !== 16'd5 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_count: writes=%0d byte_count=%0d overflow=%b required 5/5/0", n_wr - w0, byte_count, overflow);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        start_load();
        busy = 1'b1;
        send(16'h4000, 8'h01, 0);
        send(16'h4001, 8'h02, 0);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, bank_we, cpu_wait, load_done, overflow, ram_addr, ram_din, bank_dout, byte_count} !== 53'h0) begin
            errors++;
            $display("FAIL midreset_zero: got %h required 0", {ram_we, bank_we, cpu_wait, load_done, overflow, ram_addr, ram_din, bank_dout, byte_count});
        end
        exp_q.delete();
        bank_q.delete();
        dl = 1'b0;
        busy = 1'b0;
        w0 = n_wr;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (n_wr - w0 !== 0 || cpu_wait !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: writes=%0d cpu_wait=%b required 0/0", n_wr - w0, cpu_wait);
        end
        test_basic();
    endtask

    task automatic test_restore_busy();
        bit seen;
        int early;
        seen = 0;
        early = 0;
        start_load();
        send(16'h5000, 8'h77, 1);
        end_load();
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ram_we) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL restore_write: ram_we got 0 within 10 cycles, required 1");
        end
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bank_we || load_done) early++;
        end
        checks++;
        if (early !== 0 || cpu_wait !== 1'b1) begin
            errors++;
            $display("FAIL restore_hold: early strobes=%0d cpu_wait=%b required 0/1", early, cpu_wait);
        end
        busy = 1'b0;
        @(negedge clk);
        checks++;
        if (bank_we !== 1'b1 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL restore_bank: bank_we=%b load_done=%b required 1/0", bank_we, load_done);
        end
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1 || cpu_wait !== 1'b0) begin
            errors++;
            $display("FAIL restore_done: load_done=%b cpu_wait=%b required 1/0", load_done, cpu_wait);
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_held_wr();
        test_overflow();
        test_full_pushpop();
        test_reset_mid_load();
        test_restore_busy();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
